// File: rtl/pipe_rr_arbiter_if.sv
// Handshake bundle between the N requesters, the round-robin arbiter and pipeline stage 1.
// The arbiter uses the master modport; the requester/pipeline side uses the slave modport.
interface pipe_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic             i_flush;
    logic [N-1:0]     i_req_valid;
    logic [N*W-1:0]   i_req_data;
    logic [N-1:0]     o_req_stall;
    logic [N-1:0]     o_grant;
    logic [W-1:0]     o_data;
    logic             o_valid;
    logic             i_stall;
    logic [2:0]       o_src_id;
    logic             o_busy;

    modport master (
        input  i_flush, i_req_valid, i_req_data, i_stall,
        output o_req_stall, o_grant, o_data, o_valid, o_src_id, o_busy
    );

    modport slave (
        output i_flush, i_req_valid, i_req_data, i_stall,
        input  o_req_stall, o_grant, o_data, o_valid, o_src_id, o_busy
    );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin N:1 arbiter with burst lock feeding one registered valid/data stage of the pipeline.
// Optional feature: define ARB_SRC_ID_EN to register the accepted requester index on o_src_id.
module pipe_rr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 16,
    parameter int BURST_LEN = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pipe_rr_arbiter_if.master bus
);
    localparam int         PW          = $clog2(N);
    localparam logic [3:0] BURST_LEN_C = 4'(BURST_LEN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t        state_r, state_n_s;
    logic [PW-1:0] ptr_r, ptr_n_s;
    logic [PW-1:0] owner_r, owner_n_s;
    logic [3:0]    beat_cnt_r, beat_cnt_n_s, beat_inc_s;
    logic [PW-1:0] rr_sel_s, sel_s;
    logic          rr_hit_s;
    logic          load_en_s, accept_s;
    logic [W-1:0]  data_r, sel_data_s;
    logic          valid_r;

    // The output register may load when empty or draining, and never during a flush.
    assign load_en_s  = (!valid_r || !bus.i_stall) && !bus.i_flush;
    assign sel_s      = (state_r == ST_OWN) ? owner_r : rr_sel_s;
    assign accept_s   = load_en_s && bus.i_req_valid[sel_s];
    assign sel_data_s = bus.i_req_data[int'(sel_s)*W +: W];
    assign beat_inc_s = beat_cnt_r + 4'd1;

    // Wrap-around priority search starting one past the last owner
    always_comb begin
        rr_sel_s = ptr_r;
        rr_hit_s = 1'b0;
        for (int i = 1; i <= N; i++) begin
            rr_sel_s = (!rr_hit_s && bus.i_req_valid[(int'(ptr_r) + i) % N])
                       ? PW'((int'(ptr_r) + i) % N) : rr_sel_s;
            rr_hit_s = rr_hit_s | bus.i_req_valid[(int'(ptr_r) + i) % N];
        end
    end

    // Per-requester stall: only the selected requester sees its beat taken
    always_comb begin
        bus.o_req_stall = {N{1'b1}};
        for (int k = 0; k < N; k++) begin
            bus.o_req_stall[k] = !(accept_s && (int'(sel_s) == k));
        end
    end

    // Arbitration FSM next-state logic; flush overrides every other event
    always_comb begin
        state_n_s    = state_r;
        ptr_n_s      = ptr_r;
        owner_n_s    = owner_r;
        beat_cnt_n_s = beat_cnt_r;
        if (bus.i_flush) begin
            if (state_r == ST_OWN) begin
                ptr_n_s = owner_r;
            end else begin
                ptr_n_s = ptr_r;
            end
            state_n_s    = ST_IDLE;
            beat_cnt_n_s = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (BURST_LEN == 1) begin
                            ptr_n_s = sel_s;
                        end else begin
                            owner_n_s    = sel_s;
                            beat_cnt_n_s = 4'd1;
                            state_n_s    = ST_OWN;
                        end
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (accept_s) begin
                        if (beat_inc_s == BURST_LEN_C) begin
                            ptr_n_s      = owner_r;
                            beat_cnt_n_s = 4'd0;
                            state_n_s    = ST_IDLE;
                        end else begin
                            beat_cnt_n_s = beat_inc_s;
                        end
                    end else if (load_en_s) begin
                        // Owner went quiet: release without re-arbitrating this cycle.
                        ptr_n_s      = owner_r;
                        beat_cnt_n_s = 4'd0;
                        state_n_s    = ST_IDLE;
                    end else begin
                        state_n_s = ST_OWN;
                    end
                end
                default: begin
                    state_n_s    = ST_IDLE;
                    beat_cnt_n_s = 4'd0;
                end
            endcase
        end
    end

    // FSM, pointer, owner and burst counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PW'(N - 1);
            owner_r    <= {PW{1'b0}};
            beat_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_n_s;
            ptr_r      <= ptr_n_s;
            owner_r    <= owner_n_s;
            beat_cnt_r <= beat_cnt_n_s;
        end
    end

    // Stage-1 output register; data is deliberately kept across a flush
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (bus.i_flush) begin
            valid_r <= 1'b0;
        end else if (load_en_s) begin
            if (accept_s) begin
                valid_r <= 1'b1;
                data_r  <= sel_data_s;
            end else begin
                valid_r <= 1'b0;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

`ifdef ARB_SRC_ID_EN
    logic [PW-1:0] src_id_r;

    // Source index travels with the data beat
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_id_r <= {PW{1'b0}};
        end else if (accept_s) begin
            src_id_r <= sel_s;
        end else begin
            src_id_r <= src_id_r;
        end
    end

    assign bus.o_src_id = 3'(src_id_r);
`else
    assign bus.o_src_id = 3'd0;
`endif

    // One-hot owner decode, empty while idle
    always_comb begin
        bus.o_grant = {N{1'b0}};
        if (state_r == ST_OWN) begin
            bus.o_grant[owner_r] = 1'b1;
        end else begin
            bus.o_grant = {N{1'b0}};
        end
    end

    assign bus.o_data  = data_r;
    assign bus.o_valid = valid_r;
    assign bus.o_busy  = valid_r || (state_r == ST_OWN);
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter: behavioural model compared every cycle plus directed literal checks.
module tb_pipe_rr_arbiter;
    localparam int N         = 4;
    localparam int W         = 16;
    localparam int BURST_LEN = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    pipe_rr_arbiter_if #(.N(N), .W(W)) bus ();

    pipe_rr_arbiter #(.N(N), .W(W), .BURST_LEN(BURST_LEN)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: who holds a lock (-1 none), beats taken in it, last owner.
    logic         model_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_owner;
    int           m_beats;
    int           m_last;

    initial begin
        model_en = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_src    = 0;
        m_owner  = -1;
        m_beats  = 0;
        m_last   = N - 1;
    end

    function automatic int m_sel();
        if (m_owner >= 0) return m_owner;
        for (int i = 1; i <= N; i++) begin
            if (bus.i_req_valid[(m_last + i) % N]) return (m_last + i) % N;
        end
        return (m_last + 1) % N;
    endfunction

    function automatic bit m_load();
        return (!m_valid || !bus.i_stall) && !bus.i_flush;
    endfunction

    function automatic bit m_acc();
        return m_load() && bus.i_req_valid[m_sel()];
    endfunction

    function automatic logic [W-1:0] m_sel_data();
        return bus.i_req_data[m_sel()*W +: W];
    endfunction

    function automatic logic [N-1:0] m_stall();
        logic [N-1:0] s;
        s = '1;
        if (m_acc()) s[m_sel()] = 1'b0;
        return s;
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [2:0] m_src_exp();
`ifdef ARB_SRC_ID_EN
        return 3'(m_src);
`else
        return 3'd0;
`endif
    endfunction

    // Reference behaviour advanced on every rising edge
    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_src    <= 0;
            m_owner  <= -1;
            m_beats  <= 0;
            m_last   <= N - 1;
            model_en <= 1'b1;
        end else if (bus.i_flush) begin
            m_valid <= 1'b0;
            if (m_owner >= 0) m_last <= m_owner;
            m_owner <= -1;
            m_beats <= 0;
        end else if (m_load()) begin
            if (m_acc()) begin
                m_valid <= 1'b1;
                m_data  <= m_sel_data();
                m_src   <= m_sel();
                if (BURST_LEN == 1) begin
                    m_last <= m_sel();
                end else if (m_owner < 0) begin
                    m_owner <= m_sel();
                    m_beats <= 1;
                end else if (m_beats + 1 == BURST_LEN) begin
                    m_last  <= m_owner;
                    m_owner <= -1;
                    m_beats <= 0;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end else begin
                m_valid <= 1'b0;
                if (m_owner >= 0) begin
                    m_last  <= m_owner;
                    m_owner <= -1;
                    m_beats <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_en && !rst) begin
            check("o_valid",     32'(bus.o_valid),     32'(m_valid));
            check("o_data",      32'(bus.o_data),      32'(m_data));
            check("o_grant",     32'(bus.o_grant),     32'(m_grant()));
            check("o_busy",      32'(bus.o_busy),      32'(m_valid || (m_owner >= 0)));
            check("o_req_stall", 32'(bus.o_req_stall), 32'(m_stall()));
            check("o_src_id",    32'(bus.o_src_id),    32'(m_src_exp()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [W-1:0] v);
        bus.i_req_data[k*W +: W] = v;
    endtask

    logic [W-1:0] exp_seq [9];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_seq  = '{16'hD000, 16'hD000, 16'hD001, 16'hD001, 16'hD002,
                     16'hD002, 16'hD003, 16'hD003, 16'hD000};
        rst             = 1'b1;
        bus.i_flush     = 1'b0;
        bus.i_stall     = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data",  32'(bus.o_data),  32'd0);
        check("rst_grant", 32'(bus.o_grant), 32'd0);
        check("rst_busy",  32'(bus.o_busy),  32'd0);
        check("rst_src",   32'(bus.o_src_id), 32'd0);
        check("model_ptr", 32'(m_last),      32'd3);

        // All requesters valid: bursts of two rotate 0,0,1,1,2,2,3,3,0
        for (int k = 0; k < N; k++) set_data(k, 16'hD000 + 16'(k));
        bus.i_req_valid = 4'hF;
        #1;
        check("rr_first_stall", 32'(bus.o_req_stall), 32'h0000_000E);
        for (int i = 0; i < 9; i++) begin
            step();
            check("rr_valid", 32'(bus.o_valid), 32'd1);
            check("rr_data",  32'(bus.o_data),  32'(exp_seq[i]));
        end
        bus.i_req_valid = '0;
        step();
        step();

        // Single beat from requester 2
        set_data(2, 16'hA5A5);
        bus.i_req_valid = 4'b0100;
        #1;
        check("r2_stall", 32'(bus.o_req_stall), 32'h0000_000B);
        step();
        check("r2_data",  32'(bus.o_data),  32'h0000_A5A5);
        check("r2_valid", 32'(bus.o_valid), 32'd1);
        check("r2_grant", 32'(bus.o_grant), 32'h0000_0004);
        bus.i_req_valid = '0;
        step();
        check("r2_idle_grant", 32'(bus.o_grant), 32'd0);
        check("r2_idle_busy",  32'(bus.o_busy),  32'd0);

        // Requester 1 burst held under a 5-cycle stall
        set_data(1, 16'h1111);
        bus.i_req_valid = 4'b0010;
        step();
        bus.i_stall = 1'b1;
        set_data(1, 16'h2222);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_data",  32'(bus.o_data),      32'h0000_1111);
            check("stall_valid", 32'(bus.o_valid),     32'd1);
            check("stall_req1",  32'(bus.o_req_stall[1]), 32'd1);
            check("stall_grant", 32'(bus.o_grant),     32'h0000_0002);
        end
        bus.i_stall = 1'b0;
        #1;
        check("release_stall", 32'(bus.o_req_stall), 32'h0000_000D);
        step();
        check("release_data",  32'(bus.o_data),  32'h0000_2222);
        check("release_grant", 32'(bus.o_grant), 32'd0);
        bus.i_req_valid = '0;
        step();

        // Flush while requester 3 owns; pointer 3 wraps so requester 0 wins next
        set_data(3, 16'h3333);
        set_data(0, 16'h0A0A);
        bus.i_req_valid = 4'b1000;
        step();
        check("own3_grant", 32'(bus.o_grant), 32'h0000_0008);
        bus.i_flush = 1'b1;
        bus.i_stall = 1'b1;
        #1;
        check("flush_stall", 32'(bus.o_req_stall), 32'h0000_000F);
        step();
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b0;
        check("flush_valid", 32'(bus.o_valid), 32'd0);
        check("flush_grant", 32'(bus.o_grant), 32'd0);
        check("flush_data",  32'(bus.o_data),  32'h0000_3333);
        bus.i_req_valid = 4'b1001;
        #1;
        check("wrap_stall", 32'(bus.o_req_stall), 32'h0000_000E);
        step();
        check("wrap_grant", 32'(bus.o_grant), 32'h0000_0001);
        check("wrap_data",  32'(bus.o_data),  32'h0000_0A0A);
        bus.i_req_valid = '0;
        step();
        step();

        // Owner 0 drops mid-burst with requester 1 waiting: one bubble
        set_data(0, 16'h0B0B);
        set_data(1, 16'h1B1B);
        bus.i_req_valid = 4'b0001;
        step();
        check("r0_data", 32'(bus.o_data), 32'h0000_0B0B);
        bus.i_req_valid = 4'b0010;
        #1;
        check("drop_stall", 32'(bus.o_req_stall), 32'h0000_000F);
        step();
        check("bubble_valid", 32'(bus.o_valid), 32'd0);
        check("bubble_grant", 32'(bus.o_grant), 32'd0);
        step();
        check("r1_valid", 32'(bus.o_valid), 32'd1);
        check("r1_data",  32'(bus.o_data),  32'h0000_1B1B);
        check("r1_grant", 32'(bus.o_grant), 32'h0000_0002);

        // Reset mid-burst with a held beat
        rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(bus.o_valid),  32'd0);
        check("mid_rst_data",  32'(bus.o_data),   32'd0);
        check("mid_rst_grant", 32'(bus.o_grant),  32'd0);
        check("mid_rst_busy",  32'(bus.o_busy),   32'd0);
        check("mid_rst_src",   32'(bus.o_src_id), 32'd0);
        rst = 1'b0;
        bus.i_req_valid = 4'hF;
        #1;
        check("post_rst_stall", 32'(bus.o_req_stall), 32'h0000_000E);
        step();
        check("post_rst_grant", 32'(bus.o_grant), 32'h0000_0001);
        check("post_rst_data",  32'(bus.o_data),  32'h0000_0B0B);
        bus.i_req_valid = '0;
        step();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- Round-robin arbiter that shares the stage-1 input of the valid/stall pipeline between N requesters.
- Supports an optional burst lock: one requester keeps the grant for up to BURST_LEN consecutive beats.
- Drives one registered valid/data output into the pipeline, honours the pipeline's stall, and clears on the pipeline-wide flush.

Parameters:
- N, 4, number of requesters (2..8)
- W, 16, data width per requester
- BURST_LEN, 2, maximum consecutive beats per grant (1..15); 1 means no lock, re-arbitrate every beat

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_flush  in  1  pipeline flush
- i_req_valid  in  N  per-requester valid
- i_req_data  in  N*W  requester k data at bits [k*W +: W]
- o_req_stall  out  N  per-requester stall; bit k low = requester k beat accepted this cycle
- o_grant  out  N  one-hot current owner (0 in IDLE)
- o_data  out  W  data to stage 1
- o_valid  out  1  valid to stage 1
- i_stall  in  1  stall from stage 1
- o_src_id  out  3  requester index of o_data (see Optional Feature)
- o_busy  out  1  high when o_valid is high or state is OWN

Behaviour:
Output register and handshake
- load_en = (!o_valid || !i_stall) && !i_flush.
- A beat is accepted from the selected requester k when load_en && i_req_valid[k]. Same edge: o_data <= that requester's data, o_valid <= 1.
- If load_en is high and no beat is accepted, o_valid <= 0.
- While o_valid && i_stall, o_data and o_valid hold; no acceptance.
- o_req_stall[k] = !(accept && sel==k). It is combinational from i_stall, i_flush and i_req_valid only, with no path from itself.
- Latency: accepted beat appears on o_valid/o_data the cycle after acceptance.

Round-robin pointer and selection
- ptr (log2 N bits) holds the last owner.
- In IDLE, sel = first k with i_req_valid[k], searching ptr+1, ptr+2, ..., ptr modulo N (wrap-around).

FSM
- States: IDLE, OWN. Counter beat_cnt is 4 bits.
- IDLE, accept from sel:
  - If BURST_LEN==1: ptr <= sel, stay IDLE.
  - Else: owner <= sel, beat_cnt <= 1, go to OWN.
- IDLE, no valid request: stay IDLE, ptr unchanged.
- OWN: sel = owner; all other requesters stalled.
  - Accept: beat_cnt <= beat_cnt+1. If beat_cnt+1 == BURST_LEN: ptr <= owner, go to IDLE.
  - load_en high and i_req_valid[owner] low: ptr <= owner, go to IDLE with no transfer. This costs one bubble cycle; no same-cycle re-arbitration.
  - load_en low (stall): hold state and beat_cnt.
- o_grant = onehot(owner) in OWN, 0 in IDLE.

Flush
- i_flush has priority over everything else.
- Next edge: o_valid <= 0, no acceptance that cycle (all o_req_stall high).
- If in OWN: ptr <= owner, go to IDLE. beat_cnt cleared.
- o_data is not cleared.

Reset
- o_valid=0, o_data=0, o_src_id=0, state IDLE, ptr=N-1 (requester 0 has first priority), beat_cnt=0, owner=0.
- Reset mid-burst discards the held beat; o_grant=0 and o_busy=0 after the reset edge.

Simultaneous events
- Flush and stall together: flush wins.
- Stall released while owner valid: beat transfers and a new one is accepted in the same cycle (full throughput).

Optional Feature:
- Macro ARB_SRC_ID_EN.
- Defined: o_src_id registers the accepted requester index alongside o_data, held under stall, reset 0.
- Undefined: o_src_id tied to 0 and no register is built. All other behaviour is identical.

Test Plan:
- Reset, all requesters valid continuously, i_stall=0, BURST_LEN=2 -> o_src_id sequence 0,0,1,1,2,2,3,3,0; o_valid stays 1 from cycle 2.
- Only req2 valid, data 0xA5A5, one beat -> o_data=0xA5A5 one cycle after acceptance; o_req_stall=4'b1011 on the accept cycle; back to IDLE after req2 drops.
- Req1 owns the burst, i_stall=1 for 5 cycles -> o_data/o_valid held constant; req1 stall high; beat_cnt unchanged; transfer resumes when stall drops.
- i_flush pulsed while in OWN with req3 -> o_valid=0 next cycle; o_grant=0; next grant goes to req0 (ptr=3 wraps).
- Req0 owner drops valid mid-burst while req1 valid -> one bubble cycle (o_valid=0), then req1 granted.
- i_rst asserted mid-burst with o_valid=1 -> all outputs 0 next edge; after release, req0 wins first.
